// File: rtl/sdram_cmd_bridge.sv
// sdram_cmd_bridge: RX byte-stream command engine driving a single-word
// SDRAM read/write port and returning read data / acks on a TX byte stream.
//
// Ports:
//   CLK, RST              clock, async active-low reset
//   i_data/i_stb/i_ack    RX byte stream (transfer on i_stb & i_ack)
//   o_data/o_stb/o_ack    TX byte stream (transfer on o_stb & o_ack)
//   mem_rd_req/mem_wt_req one-cycle request pulses
//   mem_adr/mem_wdata     request address / write word
//   mem_busy              controller busy, blocks new requests
//   mem_rd_stb/data       read completion strobe and word
//   mem_wt_stb            write completion strobe
module sdram_cmd_bridge #(
  parameter int ADR_W   = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 65535,
  parameter int ECHO_WR = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        i_data,
  input  logic              i_stb,
  output logic              i_ack,
  output logic [7:0]        o_data,
  output logic              o_stb,
  input  logic              o_ack,
  output logic              mem_rd_req,
  output logic              mem_wt_req,
  output logic [ADR_W-1:0]  mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_busy,
  input  logic              mem_rd_stb,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_wt_stb
);

  localparam int AB = ADR_W / 8;
  localparam int DB = DATA_W / 8;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] R_ACK = 8'h4B;
  localparam logic [7:0] R_ERR = 8'hEE;

  typedef enum logic [3:0] {
    IDLE, ADR, LEN, WDATA, WREQ, WWAIT,
    RREQ, RWAIT, TXD, ACK, ERR
  } state_t;

  state_t            state;
  logic              wr;
  logic [7:0]        wcnt;
  logic [7:0]        bcnt;
  logic [TW-1:0]     tcnt;
  logic [DATA_W-1:0] sh;

  logic acc;
  logic tmo;

  assign acc = i_stb & i_ack;

  // Limit is checked only when no byte arrives, so a byte
  // landing in the limit cycle still wins.
  assign tmo = (TIMEOUT != 0) && !i_stb &&
               (tcnt == TW'(TIMEOUT));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      wr         <= 1'b0;
      wcnt       <= '0;
      bcnt       <= '0;
      tcnt       <= '0;
      sh         <= '0;
      i_ack      <= 1'b0;
      o_data     <= '0;
      o_stb      <= 1'b0;
      mem_rd_req <= 1'b0;
      mem_wt_req <= 1'b0;
      mem_adr    <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_rd_req <= 1'b0;
      mem_wt_req <= 1'b0;
      case (state)
        IDLE: begin
          i_ack <= 1'b1;
          if (acc) begin
            bcnt <= '0;
            tcnt <= '0;
            if (i_data == OP_RD || i_data == OP_WR) begin
              wr    <= (i_data == OP_WR);
              state <= ADR;
            end else begin
              i_ack  <= 1'b0;
              o_stb  <= 1'b1;
              o_data <= R_ERR;
              state  <= ERR;
            end
          end
        end
        ADR: begin
          if (acc) begin
            tcnt    <= '0;
            mem_adr <= ADR_W'({mem_adr, i_data});
            if (bcnt == 8'(AB - 1)) begin
              bcnt  <= '0;
              state <= LEN;
            end else begin
              bcnt <= bcnt + 8'd1;
            end
          end else if (tmo) begin
            i_ack  <= 1'b0;
            o_stb  <= 1'b1;
            o_data <= R_ERR;
            state  <= ERR;
          end else if (TIMEOUT != 0) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        LEN: begin
          if (acc) begin
            tcnt <= '0;
            wcnt <= i_data;
            bcnt <= '0;
            if (wr) begin
              state <= WDATA;
            end else begin
              i_ack <= 1'b0;
              state <= RREQ;
            end
          end else if (tmo) begin
            i_ack  <= 1'b0;
            o_stb  <= 1'b1;
            o_data <= R_ERR;
            state  <= ERR;
          end else if (TIMEOUT != 0) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WDATA: begin
          if (acc) begin
            tcnt      <= '0;
            mem_wdata <= DATA_W'({mem_wdata, i_data});
            if (bcnt == 8'(DB - 1)) begin
              bcnt  <= '0;
              i_ack <= 1'b0;
              // Issue straight away when the controller is free.
              if (!mem_busy) begin
                mem_wt_req <= 1'b1;
                state      <= WWAIT;
              end else begin
                state <= WREQ;
              end
            end else begin
              bcnt <= bcnt + 8'd1;
            end
          end else if (tmo) begin
            i_ack  <= 1'b0;
            o_stb  <= 1'b1;
            o_data <= R_ERR;
            state  <= ERR;
          end else if (TIMEOUT != 0) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WREQ: begin
          if (!mem_busy) begin
            mem_wt_req <= 1'b1;
            state      <= WWAIT;
          end
        end
        WWAIT: begin
          if (mem_wt_stb) begin
            mem_adr <= mem_adr + ADR_W'(1);
            if (wcnt == 8'd0) begin
              if (ECHO_WR != 0) begin
                o_stb  <= 1'b1;
                o_data <= R_ACK;
                state  <= ACK;
              end else begin
                i_ack <= 1'b1;
                state <= IDLE;
              end
            end else begin
              wcnt  <= wcnt - 8'd1;
              bcnt  <= '0;
              tcnt  <= '0;
              i_ack <= 1'b1;
              state <= WDATA;
            end
          end
        end
        RREQ: begin
          if (!mem_busy) begin
            mem_rd_req <= 1'b1;
            state      <= RWAIT;
          end
        end
        RWAIT: begin
          if (mem_rd_stb) begin
            mem_adr <= mem_adr + ADR_W'(1);
            o_stb   <= 1'b1;
            o_data  <= mem_rd_data[DATA_W-1 -: 8];
            sh      <= DATA_W'({mem_rd_data, 8'h00});
            bcnt    <= '0;
            state   <= TXD;
          end
        end
        TXD: begin
          if (o_ack) begin
            if (bcnt == 8'(DB - 1)) begin
              o_stb <= 1'b0;
              bcnt  <= '0;
              if (wcnt == 8'd0) begin
                i_ack <= 1'b1;
                state <= IDLE;
              end else begin
                wcnt  <= wcnt - 8'd1;
                state <= RREQ;
              end
            end else begin
              o_data <= sh[DATA_W-1 -: 8];
              sh     <= DATA_W'({sh, 8'h00});
              bcnt   <= bcnt + 8'd1;
            end
          end
        end
        ACK, ERR: begin
          if (o_ack) begin
            o_stb <= 1'b0;
            i_ack <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          o_stb <= 1'b0;
          i_ack <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cmd_bridge.sv
// Scoreboard bench for sdram_cmd_bridge: directed packets push expected
// requests/TX bytes; a monitor pops and compares as the DUT presents them.
module tb_sdram_cmd_bridge;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int TO = 100;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [7:0]    i_data = '0;
  logic          i_stb = 1'b0;
  logic          i_ack;
  logic [7:0]    o_data;
  logic          o_stb;
  logic          o_ack = 1'b1;
  logic          mem_rd_req;
  logic          mem_wt_req;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_busy = 1'b0;
  logic          mem_rd_stb = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_wt_stb = 1'b0;

  sdram_cmd_bridge #(
    .ADR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .ECHO_WR(1)
  ) dut (
    .CLK(CLK), .RST(RST),
    .i_data(i_data), .i_stb(i_stb), .i_ack(i_ack),
    .o_data(o_data), .o_stb(o_stb), .o_ack(o_ack),
    .mem_rd_req(mem_rd_req), .mem_wt_req(mem_wt_req),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_busy(mem_busy), .mem_rd_stb(mem_rd_stb),
    .mem_rd_data(mem_rd_data), .mem_wt_stb(mem_wt_stb)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] adr;
    logic [DW-1:0] wd;
  } req_t;

  req_t          exp_req[$];
  logic [7:0]    exp_tx[$];
  logic [DW-1:0] rdq[$];
  int            errors = 0;
  int            checks = 0;
  logic          busy_q = 1'b0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor / scoreboard.
  initial begin
    req_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (o_stb && o_ack) begin
          if (exp_tx.size() == 0) miss("tx_extra");
          else chk("tx_byte", 64'(o_data),
                   64'(exp_tx.pop_front()));
        end
        if (mem_rd_req || mem_wt_req) begin
          chk("req_busy", 64'(busy_q), 64'd0);
          if (exp_req.size() == 0) begin
            miss("req_extra");
          end else begin
            e = exp_req.pop_front();
            chk("req_kind", 64'(mem_wt_req), 64'(e.wr));
            chk("req_adr", 64'(mem_adr), 64'(e.adr));
            if (e.wr)
              chk("req_wdata", 64'(mem_wdata), 64'(e.wd));
          end
        end
      end
      busy_q = mem_busy;
    end
  end

  // Memory responder: strobe 5 cycles after each request.
  initial begin
    logic rd;
    forever begin
      @(negedge CLK);
      if (RST && (mem_rd_req || mem_wt_req)) begin
        rd = mem_rd_req;
        repeat (5) @(posedge CLK);
        #1;
        if (rd) begin
          mem_rd_data = (rdq.size() != 0) ?
                        rdq.pop_front() : '0;
          mem_rd_stb = 1'b1;
        end else begin
          mem_wt_stb = 1'b1;
        end
        @(posedge CLK);
        #1;
        mem_rd_stb = 1'b0;
        mem_wt_stb = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    i_data = b;
    i_stb  = 1'b1;
    @(negedge CLK);
    while (!i_ack && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 1000) miss("send_stall");
    @(posedge CLK);
    #1;
    i_stb  = 1'b0;
    i_data = '0;
  endtask

  task automatic send_hdr(input logic [7:0] op,
                          input logic [AW-1:0] a,
                          input logic [7:0] len);
    send(op);
    send(a[23:16]);
    send(a[15:8]);
    send(a[7:0]);
    send(len);
  endtask

  task automatic exp_rd(input logic [AW-1:0] a,
                        input logic [DW-1:0] w);
    exp_req.push_back('{wr: 1'b0, adr: a, wd: '0});
    rdq.push_back(w);
    exp_tx.push_back(w[15:8]);
    exp_tx.push_back(w[7:0]);
  endtask

  task automatic exp_wr(input logic [AW-1:0] a,
                        input logic [DW-1:0] w);
    exp_req.push_back('{wr: 1'b1, adr: a, wd: w});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_req.size() != 0)
           && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 64'(n < 3000), 64'd1);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic wait_stb(input string name);
    int n = 0;
    while (!o_stb && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 64'(o_stb), 64'd1);
  endtask

  initial begin
    logic [7:0] d;
    logic bad;
    int n;

    // Reset state and first i_ack.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_outs",
        {i_ack, o_stb, o_data, mem_rd_req, mem_wt_req,
         mem_adr, mem_wdata}, 64'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("iack_pre", 64'(i_ack), 64'd0);
    @(negedge CLK);
    chk("iack_rise", 64'(i_ack), 64'd1);
    @(posedge CLK);
    #1;

    // Single write with echo.
    exp_wr(24'h000100, 16'hABCD);
    exp_tx.push_back(8'h4B);
    send_hdr(8'h57, 24'h000100, 8'h00);
    send(8'hAB);
    send(8'hCD);
    bad = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      if (i_ack) bad = 1'b1;
      n++;
    end while (!(o_stb && o_ack) && n < 200);
    chk("wr_iack_low", 64'(bad), 64'd0);
    wait_done("wr_done");

    // Burst read of three words across 0xFF.
    exp_rd(24'h0000FE, 16'h1111);
    exp_rd(24'h0000FF, 16'h2222);
    exp_rd(24'h000100, 16'h3333);
    send_hdr(8'h52, 24'h0000FE, 8'h02);
    wait_done("burst_done");

    // Address wrap with controller busy.
    mem_busy = 1'b1;
    exp_rd(24'hFFFFFF, 16'hAAAA);
    exp_rd(24'h000000, 16'h5555);
    send_hdr(8'h52, 24'hFFFFFF, 8'h01);
    repeat (20) @(posedge CLK);
    #1;
    mem_busy = 1'b0;
    wait_done("wrap_done");

    // Bad opcode then a valid read.
    exp_tx.push_back(8'hEE);
    send(8'h41);
    wait_done("badop_done");
    exp_rd(24'h000010, 16'h9876);
    send_hdr(8'h52, 24'h000010, 8'h00);
    wait_done("after_bad_done");

    // Timeout: 100 idle cycles aborts.
    exp_tx.push_back(8'hEE);
    send(8'h57);
    send(8'h00);
    wait_done("tmo_err_done");

    // Byte at idle cycle 99 continues.
    exp_wr(24'h001000, 16'h1234);
    exp_tx.push_back(8'h4B);
    send(8'h57);
    send(8'h00);
    repeat (99) @(posedge CLK);
    #1;
    send(8'h10);
    send(8'h00);
    send(8'h00);
    send(8'h12);
    send(8'h34);
    wait_done("tmo_99_done");

    // Byte at the limit cycle wins.
    exp_wr(24'h002000, 16'h5678);
    exp_tx.push_back(8'h4B);
    send(8'h57);
    send(8'h00);
    repeat (100) @(posedge CLK);
    #1;
    send(8'h20);
    send(8'h00);
    send(8'h00);
    send(8'h56);
    send(8'h78);
    wait_done("tmo_100_done");

    // TX backpressure mid-read.
    o_ack = 1'b0;
    exp_rd(24'h000040, 16'hC0DE);
    exp_rd(24'h000041, 16'hBEEF);
    send_hdr(8'h52, 24'h000040, 8'h01);
    wait_stb("bp_stb_seen");
    d = o_data;
    bad = 1'b0;
    repeat (50) begin
      @(negedge CLK);
      if (!o_stb || o_data !== d || mem_rd_req)
        bad = 1'b1;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    chk("bp_first", 64'(d), 64'hC0);
    @(posedge CLK);
    #1;
    o_ack = 1'b1;
    wait_done("bp_done");

    // Reset in the middle of a burst.
    o_ack = 1'b0;
    exp_req.push_back('{wr: 1'b0, adr: 24'h000080, wd: '0});
    rdq.push_back(16'h0102);
    send_hdr(8'h52, 24'h000080, 8'h02);
    wait_stb("rst_stb_seen");
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("rst_mid_outs",
        {i_ack, o_stb, o_data, mem_rd_req, mem_wt_req,
         mem_adr, mem_wdata}, 64'd0);
    chk("rst_req_seen", 64'(exp_req.size()), 64'd0);
    exp_tx.delete();
    exp_req.delete();
    rdq.delete();
    o_ack = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_iack_pre", 64'(i_ack), 64'd0);
    @(negedge CLK);
    chk("rst_iack_rise", 64'(i_ack), 64'd1);
    @(posedge CLK);
    #1;
    exp_rd(24'h000033, 16'h7777);
    send_hdr(8'h52, 24'h000033, 8'h00);
    wait_done("post_rst_done");

    repeat (20) @(posedge CLK);
    chk("tail_req_empty", 64'(exp_req.size()), 64'd0);
    chk("tail_tx_empty", 64'(exp_tx.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_bridge.md
Name: sdram_cmd_bridge

Overview:
- Byte-stream command engine between the RX byte FIFO, the SDRAM controller's single-word read/write port and the TX byte FIFO.
- Parametrised successor of the fixed 24-bit-address / 16-bit-data UART-to-SDRAM path.
- Adds configurable address width and data width, burst length per command, address auto-increment with wrap, write acknowledge, error responses and an inter-byte timeout.

Parameters:
- ADR_W, 24, SDRAM word address width; multiple of 8, minimum 8; sent as ADR_W/8 bytes.
- DATA_W, 16, SDRAM word width; multiple of 8; DB = DATA_W/8 bytes per word.
- TIMEOUT, 65535, maximum idle cycles between bytes of one packet; 0 disables the timeout.
- ECHO_WR, 1, when 1 a completed write command returns 0x4B.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- i_data  in  8  RX byte.
- i_stb  in  1  RX byte valid.
- i_ack  out  1  bridge ready; a byte transfers when i_stb & i_ack.
- o_data  out  8  TX byte.
- o_stb  out  1  TX byte valid.
- o_ack  in  1  TX sink ready; a byte transfers when o_stb & o_ack.
- mem_rd_req  out  1  one-cycle read request pulse.
- mem_wt_req  out  1  one-cycle write request pulse.
- mem_adr  out  ADR_W  request address.
- mem_wdata  out  DATA_W  write word.
- mem_busy  in  1  controller busy; no request may be issued while it is high.
- mem_rd_stb  in  1  one-cycle pulse; mem_rd_data is valid in that cycle.
- mem_rd_data  in  DATA_W  read word.
- mem_wt_stb  in  1  one-cycle write-complete pulse.

Behaviour:
- Protocol, multi-byte fields MSB first.
  - Read: 0x52, ADR (ADR_W/8 bytes), LEN (1 byte). N = LEN+1 words.
  - Write: 0x57, ADR, LEN, then N*DB data bytes.
- Reset (RST=0): all outputs 0, state IDLE, counters 0. All outputs are registered. i_ack rises in the first cycle after RST deasserts.
- States and transitions:
  - IDLE: take opcode. 0x52/0x57 -> ADR. Any other value -> ERR.
  - ADR: shift in ADR_W/8 bytes -> LEN.
  - LEN: latch LEN. Read -> RREQ. Write -> WDATA.
  - WDATA: collect DB bytes into mem_wdata -> WREQ.
  - WREQ: wait for mem_busy=0, pulse mem_wt_req for 1 cycle -> WWAIT.
  - WWAIT: on mem_wt_stb, decrement word count and increment mem_adr. Words remaining -> WDATA. Done -> ACK if ECHO_WR=1, else IDLE.
  - RREQ: wait for mem_busy=0, pulse mem_rd_req -> RWAIT.
  - RWAIT: on mem_rd_stb, capture mem_rd_data into the shift register -> TXD.
  - TXD: send DB bytes MSB first. Next word -> RREQ. Done -> IDLE.
  - ACK: hold 0x4B until accepted -> IDLE.
  - ERR: hold 0xEE until accepted -> IDLE.
- i_ack is 1 only in IDLE, ADR, LEN and WDATA. It is 0 in every other state, so no RX byte is consumed during memory or TX activity.
- o_stb/o_data:
  - Asserted only in TXD, ACK and ERR.
  - Held stable while o_ack=0.
  - The next byte appears in the cycle after acceptance.
  - Maximum one byte per two cycles is acceptable.
- Address increments by 1 per word, modulo 2^ADR_W: all-ones wraps to 0.
- mem_adr and mem_wdata are stable from the request pulse until the completion strobe.
- Only one memory request is outstanding at a time. mem_rd_stb/mem_wt_stb arriving in an unexpected state are ignored.
- Timeout:
  - Counter runs in ADR, LEN and WDATA while i_stb=0. It clears on every accepted byte.
  - Reaching TIMEOUT aborts the partial packet -> ERR.
  - A byte accepted in the same cycle as the limit wins: no error.
  - The counter does not run in IDLE or in memory/TX states.
- Reset mid-operation: immediate return to IDLE and all outputs 0. The pending memory transaction is abandoned; the controller shares RST.
- Latency: write request pulse is issued 1 cycle after the last data byte when mem_busy=0. The first read byte is presented 1 cycle after mem_rd_stb.

Test Plan:
- Single write: RX 57 00 01 00 00 AB CD; respond with mem_wt_stb 5 cycles after the request -> exactly one mem_wt_req with mem_adr=0x000100 and mem_wdata=0xABCD; then TX 4B; i_ack=0 from WREQ until ACK is accepted.
- Burst read: RX 52 00 00 FE 02; supply read words 1111, 2222, 3333 -> mem_adr 0x0000FE, 0x0000FF, 0x000100 in order; TX 11 11 22 22 33 33; no extra request.
- Wrap plus mem_busy: read at FF FF FF with LEN 01, mem_busy held high 20 cycles -> no mem_rd_req while busy; then requests to 0xFFFFFF and 0x000000.
- Bad opcode: RX 41 -> TX EE. A following valid read completes normally.
- Timeout with TIMEOUT=100: RX 57 00 then 100 idle cycles -> TX EE and IDLE. Repeat with the next byte at idle cycle 99 -> packet continues, no EE. Repeat with a byte accepted at cycle 100 -> no EE.
- Backpressure and reset:
  - o_ack=0 for 50 cycles mid-read -> o_data/o_stb stable, no new mem_rd_req.
  - RST pulse mid-burst -> all outputs 0 at once; i_ack=1 one cycle after release; new command accepted.
